// File: rtl/bcd_sequencer.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a start/done handshake.
// It produces DIGITS BCD nibbles from a W-bit unsigned value and flags any high digits that were lost.
module bcd_sequencer #(
  parameter int W      = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [W-1:0]          bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic                  overflow_o
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [SW-1:0] shreg_q,  shreg_d;
  logic          lost_q,   lost_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          done_q,   done_d;
  logic [BW-1:0] digits_q, digits_d;
  logic          ovf_q,    ovf_d;

  logic [BW-1:0] bcd_adj;
  logic [SW-1:0] shifted;

  // Every nibble is corrected from its pre-shift value, all in parallel.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (shreg_q[W+4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = shreg_q[W+4*i +: 4] + 4'd3;
      else                             bcd_adj[4*i +: 4] = shreg_q[W+4*i +: 4];
    end
    shifted = {bcd_adj[BW-2:0], shreg_q[W-1:0], 1'b0};
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path can infer a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    lost_d   = lost_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          shreg_d = {{BW{1'b0}}, bin_i};
          lost_d  = 1'b0;
          cnt_d   = CW'(W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shifted;
        lost_d  = lost_q | bcd_adj[BW-1];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        digits_d = shreg_q[SW-1:W];
        ovf_d    = lost_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and overrides everything.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      lost_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      lost_q   <= lost_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  // Done is raised only on entry to IDLE, so it never overlaps Busy.
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign digits_o   = digits_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bcd_sequencer.sv
// Directed bench for bcd_sequencer: default (W=5,D=2), W=8/D=2 and W=8/D=3 instances.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [7:0]  bin;
  logic [2:0]  busy, done, ovf;
  logic [7:0]  dig_a, dig_b;
  logic [11:0] dig_c;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  bcd_sequencer #(.W(5), .DIGITS(2)) u_a (
    .clock_i(clk), .reset_i(rst), .start_i(start[0]), .bin_i(bin[4:0]),
    .busy_o(busy[0]), .done_o(done[0]), .digits_o(dig_a), .overflow_o(ovf[0]));

  bcd_sequencer #(.W(8), .DIGITS(2)) u_b (
    .clock_i(clk), .reset_i(rst), .start_i(start[1]), .bin_i(bin),
    .busy_o(busy[1]), .done_o(done[1]), .digits_o(dig_b), .overflow_o(ovf[1]));

  bcd_sequencer #(.W(8), .DIGITS(3)) u_c (
    .clock_i(clk), .reset_i(rst), .start_i(start[2]), .bin_i(bin),
    .busy_o(busy[2]), .done_o(done[2]), .digits_o(dig_c), .overflow_o(ovf[2]));

  always @(negedge clk) if ((busy & done) != 3'b000) overlap++;

  typedef struct {
    int         sel;
    logic [7:0] bin;
    logic [11:0] dig;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [11:0] dig_of(int s);
    case (s)
      0:       return {4'h0, dig_a};
      1:       return {4'h0, dig_b};
      default: return dig_c;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_conv(int sel, logic [7:0] b, logic [11:0] ed, logic eo, int lat, string tag);
    int n;
    start[sel] = 1'b1;
    bin        = b;
    @(negedge clk);
    start[sel] = 1'b0;
    bin        = ~b;
    check({tag, " busy"}, 32'(busy[sel]), 32'd1);
    n = 0;
    while (!done[sel] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " digits"}, 32'(dig_of(sel)), 32'(ed));
    check({tag, " overflow"}, 32'(ovf[sel]), 32'(eo));
    @(negedge clk);
    check({tag, " done width"}, 32'(done[sel]), 32'd0);
    check({tag, " hold"}, 32'(dig_of(sel)), 32'(ed));
  endtask

  initial begin
    int n;
    int dones;
    logic [7:0] model;

    vecs[0]  = '{0, 8'd31,  12'h031, 1'b0, 6};
    vecs[1]  = '{0, 8'd0,   12'h000, 1'b0, 6};
    vecs[2]  = '{0, 8'd10,  12'h010, 1'b0, 6};
    vecs[3]  = '{0, 8'd19,  12'h019, 1'b0, 6};
    vecs[4]  = '{1, 8'd255, 12'h055, 1'b1, 9};
    vecs[5]  = '{1, 8'd99,  12'h099, 1'b0, 9};
    vecs[6]  = '{1, 8'd100, 12'h000, 1'b1, 9};
    vecs[7]  = '{1, 8'd128, 12'h028, 1'b1, 9};
    vecs[8]  = '{2, 8'd200, 12'h200, 1'b0, 9};
    vecs[9]  = '{2, 8'd255, 12'h255, 1'b0, 9};
    vecs[10] = '{2, 8'd0,   12'h000, 1'b0, 9};
    vecs[11] = '{2, 8'd137, 12'h137, 1'b0, 9};

    rst   = 1'b1;
    start = 3'b000;
    bin   = 8'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset busy", 32'(busy[s]), 32'd0);
      check("reset done", 32'(done[s]), 32'd0);
      check("reset digits", 32'(dig_of(s)), 32'd0);
      check("reset overflow", 32'(ovf[s]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_conv(vecs[i].sel, vecs[i].bin, vecs[i].dig, vecs[i].ovf, vecs[i].lat, $sformatf("vec%0d", i));

    // Back-to-back sweep 0..31 with Start held high; Bin advanced in each Done cycle.
    start[0] = 1'b1;
    bin      = 8'd0;
    for (int i = 0; i < 32; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done[0] && n < 20);
      model = 8'(((i / 10) << 4) | (i % 10));
      check($sformatf("sweep%0d spacing", i), n, 7);
      check($sformatf("sweep%0d digits", i), 32'(dig_a), 32'(model));
      if (i < 31) bin = 8'(i + 1);
      else        start[0] = 1'b0;
    end
    repeat (10) @(negedge clk);
    check("sweep idle", 32'(busy[0]), 32'd0);

    // Start re-pulsed with changing Bin while busy: ignored.
    start[0] = 1'b1;
    bin      = 8'd23;
    @(negedge clk);
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      start[0] = ~start[0];
      bin      = 8'(k * 3 + 1);
      @(negedge clk);
      if (done[0]) dones++;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done[0]) dones++;
    end
    check("repulse done count", dones, 1);
    check("repulse digits", 32'(dig_a), 32'h23);

    // Reset mid-SHIFT: no Done, outputs cleared.
    start[0] = 1'b1;
    bin      = 8'd27;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort digits", 32'(dig_a), 32'd0);
    check("abort overflow", 32'(ovf[0]), 32'd0);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done[0]) dones++;
    end
    check("abort no done", dones, 0);
    run_conv(0, 8'd9, 12'h009, 1'b0, 6, "after abort");

    // Reset and Start on the same edge: Reset wins.
    rst      = 1'b1;
    start[0] = 1'b1;
    bin      = 8'd5;
    @(negedge clk);
    check("rst+start busy", 32'(busy[0]), 32'd0);
    rst      = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    check("rst+start idle", 32'(busy[0]), 32'd0);

    check("busy/done overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
